// File: rtl/digit_seq_pkg.sv
// Shared widths, FSM state encoding and count-direction codes for the
// seven-segment digit sequencer.
package digit_seq_pkg;

  localparam int DIGIT_W = 4;

  typedef enum logic {
    ST_RUNNING = 1'b0,
    ST_PAUSED  = 1'b1
  } state_t;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/btn_debounce.sv
// Debounces one synchronized pushbutton and emits a registered one-cycle
// press pulse in the cycle after the debounced level rises.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 65536
) (
  input  logic clk,
  input  logic rst,
  input  logic in_sync,
  output logic level,
  output logic press
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt;
  logic             level_d;

  // The count only runs while the input disagrees with the accepted level,
  // so any bounce back to the accepted level restarts it from zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      level   <= 1'b0;
      level_d <= 1'b0;
      press   <= 1'b0;
    end else begin
      level_d <= level;
      press   <= level & ~level_d;
      if (in_sync == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= in_sync;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/digit_sequencer.sv
// Produces the 4-bit digit for the seg7 decoder: exact-period prescaler,
// up/down wrap at MAX_DIGIT, debounced run/pause and single-step buttons.
module digit_sequencer
  import digit_seq_pkg::*;
#(
  parameter int TICK_DIV        = 10000000,
  parameter int MAX_DIGIT       = 6,
  parameter int DEBOUNCE_CYCLES = 65536
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               btn_run_raw,
  input  logic               btn_step_raw,
  input  logic               dir_raw,
  output logic [DIGIT_W-1:0] digit,
  output logic               tick,
  output logic               wrap,
  output logic               running
);

  localparam int                 PRESC_W    = $clog2(TICK_DIV);
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);
  localparam logic [DIGIT_W-1:0] MAX_D      = DIGIT_W'(MAX_DIGIT);

  logic [2:0] sync_meta, sync_q;
  logic       run_level, step_level, run_press, step_press, dir_sync;
  logic       unused_levels;

  state_t             state, state_next;
  logic [PRESC_W-1:0] presc, presc_next;
  logic [DIGIT_W-1:0] digit_next;
  logic               wrap_next, terminal, advance;

  // Bit order: {dir, step, run}.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_meta <= '0;
      sync_q    <= '0;
    end else begin
      sync_meta <= {dir_raw, btn_step_raw, btn_run_raw};
      sync_q    <= sync_meta;
    end
  end

  assign dir_sync      = sync_q[2];
  assign unused_levels = run_level ^ step_level;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_run_db (
    .clk     (clk),
    .rst     (rst),
    .in_sync (sync_q[0]),
    .level   (run_level),
    .press   (run_press)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step_db (
    .clk     (clk),
    .rst     (rst),
    .in_sync (sync_q[1]),
    .level   (step_level),
    .press   (step_press)
  );

  assign terminal = (state == ST_RUNNING) && (presc == PRESC_LAST);
  assign advance  = terminal || ((state == ST_PAUSED) && step_press);

  // The prescaler only free-runs while staying in RUNNING; any pause or
  // resume restarts it so the next tick is a full period away.
  always_comb begin
    state_next = state;
    presc_next = '0;
    digit_next = digit;
    wrap_next  = 1'b0;
    if (run_press) begin
      state_next = (state == ST_RUNNING) ? ST_PAUSED : ST_RUNNING;
    end
    if ((state == ST_RUNNING) && (state_next == ST_RUNNING) && !terminal) begin
      presc_next = presc + PRESC_W'(1);
    end
    if (advance) begin
      if (dir_sync == DIR_DOWN) begin
        if (digit == '0) begin
          digit_next = MAX_D;
          wrap_next  = 1'b1;
        end else begin
          digit_next = digit - DIGIT_W'(1);
        end
      end else begin
        if (digit >= MAX_D) begin
          digit_next = '0;
          wrap_next  = 1'b1;
        end else begin
          digit_next = digit + DIGIT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_RUNNING;
      presc <= '0;
      digit <= '0;
      tick  <= 1'b0;
      wrap  <= 1'b0;
    end else begin
      state <= state_next;
      presc <= presc_next;
      digit <= digit_next;
      tick  <= advance;
      wrap  <= wrap_next;
    end
  end

  assign running = (state == ST_RUNNING);

endmodule

// File: doc/digit_sequencer.md
Name: digit_sequencer

Overview:
- Upstream stage of the seven-segment digit path. Produces the 4-bit digit value that the seg7 decoder consumes.
- Replaces the ad-hoc counter in the top level with three features:
  - an exact-period prescaler;
  - a configurable wrap value and count direction;
  - debounced run/pause and single-step pushbuttons.
- Top level drives rst = ~rst_n and connects the button/switch inputs from ui_in.

Parameters:
- TICK_DIV, 10000000: clk cycles per advance tick. Legal range ≥2, <2^24.
- MAX_DIGIT, 6: highest digit value. Legal range 1..15. Count range is 0..MAX_DIGIT.
- DEBOUNCE_CYCLES, 65536: consecutive stable cycles required before a button change is accepted. Legal range ≥1.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- btn_run_raw  input  1  asynchronous pushbutton, active-high; each press toggles run/pause.
- btn_step_raw  input  1  asynchronous pushbutton, active-high; each press advances one step while paused.
- dir_raw  input  1  asynchronous level switch; 0 = count up, 1 = count down.
- digit  output  4  current digit, 0..MAX_DIGIT; feeds seg7.
- tick  output  1  one-cycle pulse on every digit advance, whether from prescaler or step.
- wrap  output  1  one-cycle pulse coincident with tick when the digit wraps.
- running  output  1  1 = RUNNING state, 0 = PAUSED.

Behaviour:
- Interface timing: one clock, clk. Reset rst is synchronous and active-high, sampled on the rising edge of clk.
- Reset values:
  - digit = 0, tick = 0, wrap = 0, running = 1;
  - prescaler = 0;
  - synchronizers, debounce counters and debounced levels all = 0.
- Reset asserted mid-operation overrides every other event in that cycle.
- Input conditioning:
  - All three raw inputs pass through a 2-flop synchronizer.
  - Buttons then go through btn_debounce. The debounced level changes only after the synchronized input has differed from it for DEBOUNCE_CYCLES consecutive cycles. Any bounce back restarts the count.
  - A press event is a one-cycle pulse, registered, in the cycle after the debounced level rises. Releases generate no event.
  - dir is synchronized only, not debounced.
- FSM states: RUNNING, PAUSED.
  - run press: RUNNING→PAUSED or PAUSED→RUNNING, effective next cycle.
  - step press in RUNNING: ignored.
- Prescaler:
  - In RUNNING it counts 0..TICK_DIV-1. At terminal count it returns to 0 and raises an advance request, so period = exactly TICK_DIV cycles.
  - In PAUSED it is held at 0, so the first tick after resume comes TICK_DIV cycles later.
- Advance source: prescaler terminal count (RUNNING) or step press (PAUSED). At most one advance per cycle.
- Advance arithmetic, using the synchronized dir in the same cycle:
  - up: digit==MAX_DIGIT → 0 with wrap=1; otherwise digit+1.
  - down: digit==0 → MAX_DIGIT with wrap=1; otherwise digit-1.
- Output timing: digit, tick and wrap are registered. tick and wrap assert in the same cycle digit takes its new value.
- Simultaneous events:
  - Terminal count and run press in the same cycle: the advance happens, then the state goes to PAUSED and the prescaler is cleared.
  - Step press and run press in the same cycle while PAUSED: the step applies and the state goes to RUNNING.
- digit never leaves 0..MAX_DIGIT. The prescaler is width-sized with $clog2(TICK_DIV); there is no overflow path.

Decomposition:
- Package digit_seq_pkg contains:
  - DIGIT_W = 4;
  - state encoding ST_RUNNING = 1'b0, ST_PAUSED = 1'b1;
  - DIR_UP = 1'b0, DIR_DOWN = 1'b1.
- Sub-module btn_debounce (parameter DEBOUNCE_CYCLES; ports clk, rst, in_sync, level, press), instantiated twice.
- Synchronizer flops stay inline.

Test Plan:
- All scenarios use TICK_DIV=4, MAX_DIGIT=6, DEBOUNCE_CYCLES=3.
- Reset:
  - Stimulus: hold rst for 2 cycles, then release.
  - Required: digit=0, running=1, tick=0 during reset. First tick 4 cycles after release, digit=1. Ticks continue exactly every 4 cycles.
- Up wrap:
  - Stimulus: run freely.
  - Required: digit steps 0,1,…,6,0. wrap pulses only on the 6→0 tick, together with tick.
- Down wrap:
  - Stimulus: set dir_raw=1 at digit=2.
  - Required: after the sync delay, the sequence runs 2,1,0,6 with wrap on 0→6.
- Debounce:
  - Stimulus: pulse btn_run_raw high for 2 cycles → nothing happens. Then hold it high for 6 cycles.
  - Required: running drops to 0 exactly once. The prescaler stops at 0 and digit is frozen.
- Step while paused:
  - Stimulus: give 3 clean step presses.
  - Required: digit advances by 3, with one tick per press. A step press after resume changes nothing except the normal 4-cycle ticks.
- Collision and reset mid-operation:
  - Collision stimulus: a run press event landing on the prescaler terminal cycle.
  - Required: the digit advances and running goes to 0.
  - Reset stimulus: assert rst while PAUSED at digit=5.
  - Required: all outputs return to their reset values on the next edge.
